// File: rtl/crop_pkg.sv
// crop_pkg: shared types for image_crop_stream (pixel word, crop origin,
// frame FSM state) plus the origin clamp helper.
package crop_pkg;

    localparam int PIX_W = 16;
    localparam int ORG_W = 16;

    typedef logic [PIX_W-1:0] pixel_t;
    typedef logic [ORG_W-1:0] origin_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // Pull an origin back so the whole window stays inside the frame.
    function automatic origin_t clamp_origin(input origin_t org, input origin_t max_org);
        return (org > max_org) ? max_org : org;
    endfunction

endpackage

// File: rtl/crop_out_reg.sv
// crop_out_reg: one-deep output register slice for a single crop stream.
// A load overwrites the slice; the top only loads when the slice is empty
// or being drained this cycle, so nothing is lost.
// Optional CROP_TLAST_EN adds the end-of-window marker.
module crop_out_reg #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] din,
`ifdef CROP_TLAST_EN
    input  logic         last_in,
    output logic         last,
`endif
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] data
);

    // Hold one beat until the consumer takes it; a load wins over a drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
`ifdef CROP_TLAST_EN
            last  <= 1'b0;
`endif
        end else if (load) begin
            valid <= 1'b1;
            data  <= din;
`ifdef CROP_TLAST_EN
            last  <= last_in;
`endif
        end else if (ready) begin
            valid <= 1'b0;
`ifdef CROP_TLAST_EN
            last  <= 1'b0;
`endif
        end
    end

endmodule

// File: rtl/image_crop_stream.sv
// image_crop_stream: consumes one raster-order frame per ap_start and
// forwards the pixels inside each of NUM_CROPS windows to its own stream.
// Overlapping windows all receive a shared pixel in the same cycle; the
// input stalls only when a window that wants the current pixel is full.
// Define CROP_TLAST_EN to add out_TLAST on the last beat of each window.
module image_crop_stream
    import crop_pkg::*;
#(
    parameter int FP_TOTAL  = PIX_W,
    parameter int IN_ROWS   = 100,
    parameter int IN_COLS   = 160,
    parameter int OUT_ROWS  = 48,
    parameter int OUT_COLS  = 48,
    parameter int NUM_CROPS = 1
) (
    input  logic                                ap_clk,
    input  logic                                ap_rst_n,
    input  logic                                ap_start,
    output logic                                ap_done,
    output logic                                ap_idle,
    output logic                                ap_ready,
    input  logic [FP_TOTAL-1:0]                 in_TDATA,
    input  logic                                in_TVALID,
    output logic                                in_TREADY,
    input  logic [NUM_CROPS-1:0][15:0]          crop_y,
    input  logic [NUM_CROPS-1:0][15:0]          crop_x,
    output logic [NUM_CROPS-1:0][FP_TOTAL-1:0]  out_TDATA,
    output logic [NUM_CROPS-1:0]                out_TVALID,
`ifdef CROP_TLAST_EN
    output logic [NUM_CROPS-1:0]                out_TLAST,
`endif
    input  logic [NUM_CROPS-1:0]                out_TREADY
);

    localparam origin_t MAX_Y    = origin_t'(IN_ROWS - OUT_ROWS);
    localparam origin_t MAX_X    = origin_t'(IN_COLS - OUT_COLS);
    localparam origin_t WIN_H    = origin_t'(OUT_ROWS);
    localparam origin_t WIN_W    = origin_t'(OUT_COLS);
    localparam origin_t LAST_ROW = origin_t'(IN_ROWS - 1);
    localparam origin_t LAST_COL = origin_t'(IN_COLS - 1);

    state_e                      state;
    origin_t                     row, col;
    origin_t [NUM_CROPS-1:0]     org_y, org_x;
    logic    [NUM_CROPS-1:0]     hit, stall;
    logic                        accept, frame_end;

    // Window membership of the pixel at (row,col) and back-pressure per window.
    always_comb begin
        hit   = '0;
        stall = '0;
        for (int k = 0; k < NUM_CROPS; k++) begin
            hit[k]   = (row >= org_y[k]) && (row < org_y[k] + WIN_H) &&
                       (col >= org_x[k]) && (col < org_x[k] + WIN_W);
            stall[k] = hit[k] && out_TVALID[k] && !out_TREADY[k];
        end
    end

    assign in_TREADY = (state == ST_RUN) && !(|stall);
    assign accept    = in_TREADY && in_TVALID;
    assign frame_end = (row == LAST_ROW) && (col == LAST_COL);
    assign ap_idle   = (state == ST_IDLE);

    // Frame sequencing, raster position and origin capture.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state    <= ST_IDLE;
            row      <= '0;
            col      <= '0;
            org_y    <= '0;
            org_x    <= '0;
            ap_done  <= 1'b0;
            ap_ready <= 1'b0;
        end else begin
            ap_done  <= 1'b0;
            ap_ready <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (ap_start) begin
                        for (int k = 0; k < NUM_CROPS; k++) begin
                            org_y[k] <= clamp_origin(crop_y[k], MAX_Y);
                            org_x[k] <= clamp_origin(crop_x[k], MAX_X);
                        end
                        row      <= '0;
                        col      <= '0;
                        ap_ready <= 1'b1;
                        state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        if (col == LAST_COL) begin
                            col <= '0;
                            row <= row + origin_t'(1);
                        end else begin
                            col <= col + origin_t'(1);
                        end
                        if (frame_end) state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!(|out_TVALID)) begin
                        ap_done <= 1'b1;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef CROP_TLAST_EN
    localparam origin_t WIN_H_M1 = origin_t'(OUT_ROWS - 1);
    localparam origin_t WIN_W_M1 = origin_t'(OUT_COLS - 1);
    logic [NUM_CROPS-1:0] tail;

    // Bottom-right pixel of each window leaves with TLAST set.
    always_comb begin
        tail = '0;
        for (int k = 0; k < NUM_CROPS; k++)
            tail[k] = (row == org_y[k] + WIN_H_M1) && (col == org_x[k] + WIN_W_M1);
    end
`endif

    for (genvar k = 0; k < NUM_CROPS; k++) begin : g_crop
        crop_out_reg #(.W(FP_TOTAL)) u_reg (
            .clk     (ap_clk),
            .rst_n   (ap_rst_n),
            .load    (accept && hit[k]),
            .din     (in_TDATA),
`ifdef CROP_TLAST_EN
            .last_in (tail[k]),
            .last    (out_TLAST[k]),
`endif
            .ready   (out_TREADY[k]),
            .valid   (out_TVALID[k]),
            .data    (out_TDATA[k])
        );
    end

endmodule

// File: tb/tb_image_crop_stream.sv
// tb_image_crop_stream: directed frames through a two-window instance.
// Input pixel value = raster index r*160+c, so beat j of a window at
// (y,x) must be (y + j/48)*160 + x + j%48.
`timescale 1ns/1ps
module tb_image_crop_stream;

    localparam int NC = 2, IR = 100, IC = 160, OR = 48, OC = 48;
    localparam int NPIX = IR * IC, NBEAT = OR * OC;

    logic                 ap_clk = 1'b0, ap_rst_n = 1'b0, ap_start = 1'b0;
    logic                 ap_done, ap_idle, ap_ready;
    logic [15:0]          in_TDATA = '0;
    logic                 in_TVALID = 1'b0;
    logic                 in_TREADY;
    logic [NC-1:0][15:0]  crop_y = '0, crop_x = '0;
    logic [NC-1:0][15:0]  out_TDATA;
    logic [NC-1:0]        out_TVALID;
    logic [NC-1:0]        out_TREADY = '0;
`ifdef CROP_TLAST_EN
    logic [NC-1:0]        out_TLAST;
`endif

    int n_cmp = 0, n_bad = 0;
    int cyc_now = 0, t_start = 0;
    int ey[NC], ex[NC];
    int beats[NC], errs[NC], first_val[NC], last_val[NC], bad_beat[NC], bad_val[NC];
    int tl_ones[NC], tl_err[NC];
    bit seen_shared[NC];
    int rdy_pulses;
    bit mon_clr = 1'b0;

    image_crop_stream #(
        .FP_TOTAL(16), .IN_ROWS(IR), .IN_COLS(IC),
        .OUT_ROWS(OR), .OUT_COLS(OC), .NUM_CROPS(NC)
    ) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start),
        .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready),
        .in_TDATA(in_TDATA), .in_TVALID(in_TVALID), .in_TREADY(in_TREADY),
        .crop_y(crop_y), .crop_x(crop_x),
        .out_TDATA(out_TDATA), .out_TVALID(out_TVALID),
`ifdef CROP_TLAST_EN
        .out_TLAST(out_TLAST),
`endif
        .out_TREADY(out_TREADY)
    );

    always #5 ap_clk = ~ap_clk;

    always @(posedge ap_clk) cyc_now++;

    // Output scoreboard: every accepted beat is checked against the raster model.
    always @(negedge ap_clk) begin
        int exp_v;
        if (mon_clr || !ap_rst_n) begin
            rdy_pulses = 0;
            for (int k = 0; k < NC; k++) begin
                beats[k] = 0; errs[k] = 0; first_val[k] = -1; last_val[k] = -1;
                bad_beat[k] = 0; bad_val[k] = 0; tl_ones[k] = 0; tl_err[k] = 0;
                seen_shared[k] = 1'b0;
            end
        end else begin
            if (ap_ready) rdy_pulses++;
            for (int k = 0; k < NC; k++) begin
                if (out_TVALID[k] && out_TREADY[k]) begin
                    exp_v = (ey[k] + beats[k] / OC) * IC + ex[k] + beats[k] % OC;
                    if (int'(out_TDATA[k]) != exp_v) begin
                        if (errs[k] == 0) begin
                            bad_beat[k] = beats[k];
                            bad_val[k]  = int'(out_TDATA[k]);
                        end
                        errs[k]++;
                    end
                    if (beats[k] == 0) first_val[k] = int'(out_TDATA[k]);
                    last_val[k] = int'(out_TDATA[k]);
                    if (out_TDATA[k] == 16'd3230) seen_shared[k] = 1'b1;
`ifdef CROP_TLAST_EN
                    if (out_TLAST[k]) tl_ones[k]++;
                    if (out_TLAST[k] !== (beats[k] == NBEAT - 1)) tl_err[k]++;
`endif
                    beats[k]++;
                end
            end
        end
    end

    task automatic mon_clear();
        mon_clr = 1'b1;
        @(negedge ap_clk);
        @(posedge ap_clk); #1;
        mon_clr = 1'b0;
    endtask

    task automatic start_frame();
        @(posedge ap_clk); #1;
        ap_start = 1'b1;
        @(posedge ap_clk); #1;
        ap_start = 1'b0;
        t_start  = cyc_now;
    endtask

    // Stream pixels with the given valid/ready percentages; stop early at stop_at (-1 = full frame).
    task automatic run_pixels(input int vpct, input int rpct, input int stop_at, output bit to);
        int idx = 0, cyc = 0;
        bit hs;
        to = 1'b0;
        while (idx < NPIX && (stop_at < 0 || idx < stop_at)) begin
            in_TVALID = (int'($urandom_range(99)) < vpct);
            in_TDATA  = 16'(idx);
            ap_start  = (idx == 100);
            for (int k = 0; k < NC; k++) out_TREADY[k] = (int'($urandom_range(99)) < rpct);
            @(negedge ap_clk);
            hs = in_TVALID && in_TREADY;
            @(posedge ap_clk); #1;
            if (hs) idx++;
            cyc++;
            if (cyc > 60000) begin to = 1'b1; break; end
        end
        in_TVALID = 1'b0;
        ap_start  = 1'b0;
    endtask

    task automatic wait_done(input int rpct, output int lat, output bit to);
        to  = 1'b1;
        lat = -1;
        for (int i = 0; i < 500; i++) begin
            for (int k = 0; k < NC; k++) out_TREADY[k] = (int'($urandom_range(99)) < rpct);
            @(negedge ap_clk);
            if (ap_done) begin lat = cyc_now - t_start; to = 1'b0; break; end
            @(posedge ap_clk); #1;
        end
        @(posedge ap_clk); #1;
    endtask

    task automatic test_reset();
        ap_rst_n = 1'b0;
        repeat (3) @(posedge ap_clk);
        @(negedge ap_clk);
        n_cmp++; if (ap_idle !== 1'b1)  begin n_bad++; $display("FAIL reset_idle: got %b expected 1", ap_idle); end
        n_cmp++; if (ap_done !== 1'b0)  begin n_bad++; $display("FAIL reset_done: got %b expected 0", ap_done); end
        n_cmp++; if (ap_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b expected 0", ap_ready); end
        n_cmp++; if (in_TREADY !== 1'b0) begin n_bad++; $display("FAIL reset_in_tready: got %b expected 0", in_TREADY); end
        n_cmp++; if (out_TVALID !== 2'b00) begin n_bad++; $display("FAIL reset_tvalid: got %b expected 00", out_TVALID); end
        n_cmp++; if (out_TDATA !== 32'h0) begin n_bad++; $display("FAIL reset_tdata: got %h expected 0", out_TDATA); end
        @(posedge ap_clk); #1;
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        n_cmp++; if (ap_idle !== 1'b1 || in_TREADY !== 1'b0) begin
            n_bad++; $display("FAIL idle_after_reset: got idle=%b tready=%b expected idle=1 tready=0", ap_idle, in_TREADY);
        end
    endtask

    // Two overlapping windows, consumer always ready.
    task automatic test_overlap_ready();
        int  f_exp[NC] = '{1610, 3230};
        int  l_exp[NC] = '{9177, 10797};
        int  lat;
        bit  to_px, to_dn;
        crop_y[0] = 16'd10; crop_x[0] = 16'd10; ey[0] = 10; ex[0] = 10;
        crop_y[1] = 16'd20; crop_x[1] = 16'd30; ey[1] = 20; ex[1] = 30;
        mon_clear();
        start_frame();
        run_pixels(100, 100, -1, to_px);
        wait_done(100, lat, to_dn);
        n_cmp++; if (to_px || to_dn) begin n_bad++; $display("FAIL ready_timeout: got px=%b done=%b expected 0 0", to_px, to_dn); end
        n_cmp++; if (lat < 16000 || lat > 16010) begin n_bad++; $display("FAIL ready_done_latency: got %0d expected 16000..16010", lat); end
        n_cmp++; if (rdy_pulses != 1) begin n_bad++; $display("FAIL ready_ap_ready_pulses: got %0d expected 1", rdy_pulses); end
        for (int k = 0; k < NC; k++) begin
            n_cmp++; if (beats[k] != NBEAT) begin n_bad++; $display("FAIL ready_beats[%0d]: got %0d expected %0d", k, beats[k], NBEAT); end
            n_cmp++; if (errs[k] != 0) begin n_bad++; $display("FAIL ready_data[%0d]: beat %0d got %0d, %0d bad beats expected 0", k, bad_beat[k], bad_val[k], errs[k]); end
            n_cmp++; if (first_val[k] != f_exp[k]) begin n_bad++; $display("FAIL ready_first[%0d]: got %0d expected %0d", k, first_val[k], f_exp[k]); end
            n_cmp++; if (last_val[k] != l_exp[k]) begin n_bad++; $display("FAIL ready_last[%0d]: got %0d expected %0d", k, last_val[k], l_exp[k]); end
            n_cmp++; if (!seen_shared[k]) begin n_bad++; $display("FAIL ready_shared3230[%0d]: got 0 expected 1", k); end
`ifdef CROP_TLAST_EN
            n_cmp++; if (tl_ones[k] != 1 || tl_err[k] != 0) begin n_bad++; $display("FAIL ready_tlast[%0d]: got ones=%0d bad=%0d expected 1 0", k, tl_ones[k], tl_err[k]); end
`endif
        end
    endtask

    // Random source gaps and consumer stalls; second window clamped to (52,112).
    task automatic test_random_stall();
        int  f_exp[NC] = '{1610, 8432};
        int  l_exp[NC] = '{9177, 15999};
        int  lat;
        bit  to_px, to_dn;
        crop_y[0] = 16'd10; crop_x[0] = 16'd10;  ey[0] = 10; ex[0] = 10;
        crop_y[1] = 16'd80; crop_x[1] = 16'd150; ey[1] = 52; ex[1] = 112;
        mon_clear();
        start_frame();
        run_pixels(70, 60, -1, to_px);
        wait_done(60, lat, to_dn);
        n_cmp++; if (to_px || to_dn) begin n_bad++; $display("FAIL stall_timeout: got px=%b done=%b expected 0 0", to_px, to_dn); end
        for (int k = 0; k < NC; k++) begin
            n_cmp++; if (beats[k] != NBEAT) begin n_bad++; $display("FAIL stall_beats[%0d]: got %0d expected %0d", k, beats[k], NBEAT); end
            n_cmp++; if (errs[k] != 0) begin n_bad++; $display("FAIL stall_data[%0d]: beat %0d got %0d, %0d bad beats expected 0", k, bad_beat[k], bad_val[k], errs[k]); end
            n_cmp++; if (first_val[k] != f_exp[k]) begin n_bad++; $display("FAIL stall_first[%0d]: got %0d expected %0d", k, first_val[k], f_exp[k]); end
            n_cmp++; if (last_val[k] != l_exp[k]) begin n_bad++; $display("FAIL stall_last[%0d]: got %0d expected %0d", k, last_val[k], l_exp[k]); end
`ifdef CROP_TLAST_EN
            n_cmp++; if (tl_ones[k] != 1 || tl_err[k] != 0) begin n_bad++; $display("FAIL stall_tlast[%0d]: got ones=%0d bad=%0d expected 1 0", k, tl_ones[k], tl_err[k]); end
`endif
        end
    endtask

    // Reset at pixel 5000, then a clean frame must start over from (0,0).
    task automatic test_reset_midframe();
        int  f_exp[NC] = '{1610, 3230};
        int  lat;
        bit  to_px, to_dn;
        crop_y[0] = 16'd10; crop_x[0] = 16'd10; ey[0] = 10; ex[0] = 10;
        crop_y[1] = 16'd20; crop_x[1] = 16'd30; ey[1] = 20; ex[1] = 30;
        mon_clear();
        start_frame();
        run_pixels(80, 50, 5000, to_px);
        ap_rst_n = 1'b0;
        #1;
        n_cmp++; if (out_TVALID !== 2'b00 || out_TDATA !== 32'h0) begin
            n_bad++; $display("FAIL midreset_outputs: got valid=%b data=%h expected 00 0", out_TVALID, out_TDATA);
        end
        n_cmp++; if (ap_idle !== 1'b1 || in_TREADY !== 1'b0) begin
            n_bad++; $display("FAIL midreset_ctrl: got idle=%b tready=%b expected 1 0", ap_idle, in_TREADY);
        end
        repeat (2) @(posedge ap_clk);
        #1 ap_rst_n = 1'b1;
        mon_clear();
        start_frame();
        run_pixels(100, 100, -1, to_px);
        wait_done(100, lat, to_dn);
        n_cmp++; if (to_px || to_dn) begin n_bad++; $display("FAIL refr_timeout: got px=%b done=%b expected 0 0", to_px, to_dn); end
        for (int k = 0; k < NC; k++) begin
            n_cmp++; if (beats[k] != NBEAT) begin n_bad++; $display("FAIL refr_beats[%0d]: got %0d expected %0d", k, beats[k], NBEAT); end
            n_cmp++; if (errs[k] != 0) begin n_bad++; $display("FAIL refr_data[%0d]: beat %0d got %0d, %0d bad beats expected 0", k, bad_beat[k], bad_val[k], errs[k]); end
            n_cmp++; if (first_val[k] != f_exp[k]) begin n_bad++; $display("FAIL refr_first[%0d]: got %0d expected %0d", k, first_val[k], f_exp[k]); end
        end
    endtask

    initial begin
        test_reset();
        test_overlap_ready();
        test_random_stall();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
